// File: rtl/banked_word_memory.sv
// Banked 32-bit word store: byte-lane load/store port A and read-only fetch port I over
// NBANKS synchronous RAM banks, with same-bank arbitration, RV32 load extraction and error flags.
module banked_word_memory #(
    parameter int NBANKS  = 16,
    parameter int BANK_AW = 11,
    parameter int OUTREG  = 0,
    parameter int AW      = $clog2(NBANKS) + BANK_AW + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [1:0]    a_size,
    input  logic          a_uns,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic          a_rvalid,
    output logic [31:0]   a_rdata,
    output logic          a_err,
    input  logic          i_req,
    output logic          i_ready,
    input  logic [AW-1:0] i_addr,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_err
);

    localparam int BW = AW - BANK_AW - 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    function automatic logic out_of_range(input logic [BW-1:0] bank);
        return {1'b0, bank} >= (BW + 1)'(NBANKS);
    endfunction

    // Shift the addressed lane down, then trim to the access size and extend.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic uns, input logic [1:0] lane);
        logic [31:0] s;
        s = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: return uns ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            SZ_HALF: return uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    logic [BW-1:0]      a_bank, i_bank;
    logic [BANK_AW-1:0] a_row, i_row;
    logic [1:0]         a_lane, i_lane;

    assign a_bank = a_addr[AW-1:BANK_AW+2];
    assign a_row  = a_addr[BANK_AW+1:2];
    assign a_lane = a_addr[1:0];
    assign i_bank = i_addr[AW-1:BANK_AW+2];
    assign i_row  = i_addr[BANK_AW+1:2];
    assign i_lane = i_addr[1:0];

    // A owns any bank it requests; I waits for a cycle where A is elsewhere or idle.
    assign a_ready = rst_n;
    assign i_ready = rst_n && !(a_req && (a_bank == i_bank));

    logic a_fire, i_fire;
    assign a_fire = a_req && a_ready;
    assign i_fire = i_req && i_ready;

    logic        a_err_c, i_err_c;
    logic [31:0] a_wdata_rep;
    logic [3:0]  a_be;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        a_err_c     = out_of_range(a_bank);
        a_wdata_rep = a_wdata;
        a_be        = 4'hF;
        case (a_size)
            SZ_BYTE: begin
                a_wdata_rep = {4{a_wdata[7:0]}};
                a_be        = 4'b0001 << a_lane;
            end
            SZ_HALF: begin
                a_wdata_rep = {2{a_wdata[15:0]}};
                a_be        = 4'b0011 << a_lane;
                if (a_lane[0]) a_err_c = 1'b1;
            end
            SZ_WORD: begin
                if (a_lane != 2'd0) a_err_c = 1'b1;
            end
            default: a_err_c = 1'b1;
        endcase
    end

    assign i_err_c = (i_lane != 2'd0) || out_of_range(i_bank);

    logic [31:0] bank_rd [NBANKS];

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [31:0]        mem [2**BANK_AW];
        logic [31:0]        rd_q;
        logic               a_sel, i_sel, en, we;
        logic [BANK_AW-1:0] row;

        assign a_sel = a_fire && (a_bank == BW'(b));
        assign i_sel = i_fire && (i_bank == BW'(b));
        assign en    = a_sel || i_sel;
        assign we    = a_sel && a_we && !a_err_c;
        assign row   = a_sel ? a_row : i_row;

        // NOTE: RAM arrays and their read registers take no reset so they map onto block RAM.
        always_ff @(posedge clk) begin
            if (en) begin
                for (int l = 0; l < 4; l++) begin
                    if (we && a_be[l]) mem[row][8*l +: 8] <= a_wdata_rep[8*l +: 8];
                end
                rd_q <= mem[row];
            end
        end

        assign bank_rd[b] = rd_q;
    end

    logic          a_v1, a_we1, a_err1, a_uns1;
    logic [1:0]    a_size1, a_lane1;
    logic [BW-1:0] a_bank1;
    logic          i_v1, i_err1;
    logic [BW-1:0] i_bank1;

    // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_v1    <= 1'b0;
            a_we1   <= 1'b0;
            a_err1  <= 1'b0;
            a_uns1  <= 1'b0;
            a_size1 <= 2'd0;
            a_lane1 <= 2'd0;
            a_bank1 <= '0;
            i_v1    <= 1'b0;
            i_err1  <= 1'b0;
            i_bank1 <= '0;
        end else begin
            a_v1 <= a_fire;
            i_v1 <= i_fire;
            if (a_fire) begin
                a_we1   <= a_we;
                a_err1  <= a_err_c;
                a_uns1  <= a_uns;
                a_size1 <= a_size;
                a_lane1 <= a_lane;
                a_bank1 <= a_bank;
            end
            if (i_fire) begin
                i_err1  <= i_err_c;
                i_bank1 <= i_bank;
            end
        end
    end

    logic [31:0] a_result, i_result;
    assign a_result = (a_we1 || a_err1) ? 32'd0
                    : extract(bank_rd[a_bank1], a_size1, a_uns1, a_lane1);
    assign i_result = i_err1 ? 32'd0 : bank_rd[i_bank1];

    if (OUTREG == 0) begin : g_direct
        // Bank read registers can be overwritten by later traffic, so idle outputs come from a hold copy.
        logic [31:0] a_hold, i_hold;
        logic        a_err_hold, i_err_hold;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_hold     <= 32'd0;
                a_err_hold <= 1'b0;
                i_hold     <= 32'd0;
                i_err_hold <= 1'b0;
            end else begin
                if (a_v1) begin
                    a_hold     <= a_result;
                    a_err_hold <= a_err1;
                end
                if (i_v1) begin
                    i_hold     <= i_result;
                    i_err_hold <= i_err1;
                end
            end
        end

        assign a_rvalid = a_v1;
        assign a_rdata  = a_v1 ? a_result : a_hold;
        assign a_err    = a_v1 ? a_err1 : a_err_hold;
        assign i_rvalid = i_v1;
        assign i_rdata  = i_v1 ? i_result : i_hold;
        assign i_err    = i_v1 ? i_err1 : i_err_hold;
    end else begin : g_outreg
        logic        a_rvalid_q, a_err_q, i_rvalid_q, i_err_q;
        logic [31:0] a_rdata_q, i_rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_rvalid_q <= 1'b0;
                a_rdata_q  <= 32'd0;
                a_err_q    <= 1'b0;
                i_rvalid_q <= 1'b0;
                i_rdata_q  <= 32'd0;
                i_err_q    <= 1'b0;
            end else begin
                a_rvalid_q <= a_v1;
                i_rvalid_q <= i_v1;
                if (a_v1) begin
                    a_rdata_q <= a_result;
                    a_err_q   <= a_err1;
                end
                if (i_v1) begin
                    i_rdata_q <= i_result;
                    i_err_q   <= i_err1;
                end
            end
        end

        assign a_rvalid = a_rvalid_q;
        assign a_rdata  = a_rdata_q;
        assign a_err    = a_err_q;
        assign i_rvalid = i_rvalid_q;
        assign i_rdata  = i_rdata_q;
        assign i_err    = i_err_q;
    end

endmodule

// File: tb/tb_banked_word_memory.sv
// Bench for banked_word_memory: byte-addressed reference model with a per-cycle compare
// process, plus directed transactions pinned to hand-computed literals.
module tb_banked_word_memory;

    localparam int NBANKS  = 16;
    localparam int BANK_AW = 11;
    localparam int OUTREG  = 0;
    localparam int AW      = $clog2(NBANKS) + BANK_AW + 2;

    logic          clk, rst_n;
    logic          a_req, a_ready, a_we, a_uns, a_rvalid, a_err;
    logic [1:0]    a_size;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata, a_rdata;
    logic          i_req, i_ready, i_rvalid, i_err;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_rdata;

    banked_word_memory #(.NBANKS(NBANKS), .BANK_AW(BANK_AW), .OUTREG(OUTREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_ready(a_ready), .a_we(a_we), .a_size(a_size), .a_uns(a_uns),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .i_req(i_req), .i_ready(i_ready), .i_addr(i_addr),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: flat byte-addressed memory ----------------
    bit [7:0] mem_m [int unsigned];

    typedef struct {
        int unsigned due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       a_q[$], i_q[$];
    int unsigned cyc = 0;

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] rd_byte(input int unsigned k);
        return mem_m.exists(k) ? mem_m[k] : 8'h00;
    endfunction

    function automatic logic in_range(input logic [AW-1:0] addr);
        return (int'(addr) >> (BANK_AW + 2)) < NBANKS;
    endfunction

    function automatic logic model_a_err(input logic [1:0] size, input logic [AW-1:0] addr);
        if (size == 2'd3) return 1'b1;
        return (int'(addr) % nbytes(size)) != 0 || !in_range(addr);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [AW-1:0] addr);
        logic [31:0] v;
        int n;
        n = nbytes(size);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(rd_byte(int'(addr) + i)) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    always @(posedge clk) begin
        resp_t r;
        cyc++;
        if (!rst_n) begin
            a_q.delete();
            i_q.delete();
        end else begin
            if (i_req && i_ready) begin
                r.due  = cyc + OUTREG;
                r.err  = (i_addr[1:0] != 2'd0) || !in_range(i_addr);
                r.data = r.err ? 32'd0 : model_load(2'd2, 1'b0, i_addr);
                i_q.push_back(r);
            end
            if (a_req && a_ready) begin
                r.due  = cyc + OUTREG;
                r.err  = model_a_err(a_size, a_addr);
                r.data = (r.err || a_we) ? 32'd0 : model_load(a_size, a_uns, a_addr);
                if (a_we && !r.err)
                    for (int i = 0; i < nbytes(a_size); i++)
                        mem_m[int'(a_addr) + i] = a_wdata[8*i +: 8];
                a_q.push_back(r);
            end
        end
    end

    // Compare process: checks both response ports on every falling edge.
    logic [31:0] a_last = 32'd0, i_last = 32'd0;
    logic        a_last_err = 1'b0, i_last_err = 1'b0;

    always @(negedge clk) begin
        logic exp_v;
        if (!rst_n) begin
            a_q.delete();
            i_q.delete();
            a_last = 32'd0; i_last = 32'd0; a_last_err = 1'b0; i_last_err = 1'b0;
            check("rst_a_rvalid", a_rvalid, 0);
            check("rst_a_rdata", a_rdata, 0);
            check("rst_a_err", a_err, 0);
            check("rst_a_ready", a_ready, 0);
            check("rst_i_rvalid", i_rvalid, 0);
            check("rst_i_rdata", i_rdata, 0);
            check("rst_i_err", i_err, 0);
            check("rst_i_ready", i_ready, 0);
        end else begin
            exp_v = (a_q.size() > 0) && (a_q[0].due == cyc);
            check("mdl_a_rvalid", a_rvalid, exp_v);
            if (exp_v) begin
                a_last = a_q[0].data; a_last_err = a_q[0].err;
                void'(a_q.pop_front());
            end
            check("mdl_a_rdata", a_rdata, a_last);
            check("mdl_a_err", a_err, a_last_err);
            exp_v = (i_q.size() > 0) && (i_q[0].due == cyc);
            check("mdl_i_rvalid", i_rvalid, exp_v);
            if (exp_v) begin
                i_last = i_q[0].data; i_last_err = i_q[0].err;
                void'(i_q.pop_front());
            end
            check("mdl_i_rdata", i_rdata, i_last);
            check("mdl_i_err", i_err, i_last_err);
        end
    end

    // ---------------- directed transactions ----------------
    task automatic a_chk(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [AW-1:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_data, input logic exp_err);
        logic got;
        got = 1'b0;
        @(negedge clk);
        a_req = 1'b1; a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        a_req = 1'b0; a_we = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            if (a_rvalid) begin
                got = 1'b1;
                check({name, "_data"}, a_rdata, exp_data);
                check({name, "_err"}, a_err, exp_err);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic i_chk(input string name, input logic [AW-1:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
        logic got;
        got = 1'b0;
        @(negedge clk);
        i_req = 1'b1; i_addr = addr;
        @(posedge clk);
        @(negedge clk);
        i_req = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            if (i_rvalid) begin
                got = 1'b1;
                check({name, "_data"}, i_rdata, exp_data);
                check({name, "_err"}, i_err, exp_err);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_size = 2'd0; a_uns = 1'b0; a_addr = '0; a_wdata = '0;
        i_req = 1'b0; i_addr = '0;
        #2;
        check("reset_a_ready", a_ready, 0);
        check("reset_a_rdata", a_rdata, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("a_ready_after_reset", a_ready, 1);

        a_chk("sw_100",   1, 2'd2, 0, 17'h100, 32'hDEAD_BEEF, 32'h0, 0);
        a_chk("lw_100",   0, 2'd2, 0, 17'h100, 32'h0, 32'hDEAD_BEEF, 0);
        a_chk("lb_103",   0, 2'd0, 0, 17'h103, 32'h0, 32'hFFFF_FFDE, 0);
        a_chk("lbu_103",  0, 2'd0, 1, 17'h103, 32'h0, 32'h0000_00DE, 0);
        a_chk("lh_102",   0, 2'd1, 0, 17'h102, 32'h0, 32'hFFFF_DEAD, 0);
        a_chk("lhu_100",  0, 2'd1, 1, 17'h100, 32'h0, 32'h0000_BEEF, 0);
        a_chk("sb_101",   1, 2'd0, 0, 17'h101, 32'hFFFF_FF55, 32'h0, 0);
        a_chk("lw_sb",    0, 2'd2, 0, 17'h100, 32'h0, 32'hDEAD_55EF, 0);
        a_chk("sh_102",   1, 2'd1, 0, 17'h102, 32'hFFFF_1234, 32'h0, 0);
        a_chk("lw_sh",    0, 2'd2, 0, 17'h100, 32'h0, 32'h1234_55EF, 0);
        a_chk("lw_mis",   0, 2'd2, 0, 17'h102, 32'h0, 32'h0, 1);
        a_chk("sh_mis",   1, 2'd1, 0, 17'h101, 32'hFFFF_FFFF, 32'h0, 1);
        a_chk("sz3",      1, 2'd3, 0, 17'h100, 32'h0, 32'h0, 1);
        a_chk("lw_after", 0, 2'd2, 0, 17'h100, 32'h0, 32'h1234_55EF, 0);

        a_chk("sw_104",   1, 2'd2, 0, 17'h104, 32'h0BAD_F00D, 32'h0, 0);
        a_chk("sw_2000",  1, 2'd2, 0, 17'h2000, 32'hCAFE_F00D, 32'h0, 0);
        i_chk("if_mis",   17'h006, 32'h0, 1);
        i_chk("if_104",   17'h104, 32'h0BAD_F00D, 0);

        // Same-bank conflict: A wins, I follows one cycle later.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_uns = 1'b0; a_addr = 17'h100;
        i_req = 1'b1; i_addr = 17'h104;
        #1 check("arb_i_blocked", i_ready, 0);
        @(posedge clk);
        @(negedge clk);
        a_req = 1'b0;
        check("arb_a_first", a_rvalid, 1);
        check("arb_a_data", a_rdata, 32'h1234_55EF);
        check("arb_i_waits", i_rvalid, 0);
        #1 check("arb_i_free", i_ready, 1);
        @(posedge clk);
        @(negedge clk);
        i_req = 1'b0;
        check("arb_i_resp", i_rvalid, 1);
        check("arb_i_data", i_rdata, 32'h0BAD_F00D);

        // Different banks proceed together.
        @(negedge clk);
        a_req = 1'b1; a_addr = 17'h100;
        i_req = 1'b1; i_addr = 17'h2000;
        #1 check("par_i_ready", i_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a_req = 1'b0; i_req = 1'b0;
        check("par_a_valid", a_rvalid, 1);
        check("par_a_data", a_rdata, 32'h1234_55EF);
        check("par_i_valid", i_rvalid, 1);
        check("par_i_data", i_rdata, 32'hCAFE_F00D);

        // Back-to-back loads, then hold of the last value.
        @(negedge clk);
        a_req = 1'b1; a_addr = 17'h100;
        @(posedge clk);
        @(negedge clk);
        a_addr = 17'h104;
        check("b2b_first", a_rdata, 32'h1234_55EF);
        @(posedge clk);
        @(negedge clk);
        a_req = 1'b0;
        check("b2b_second_v", a_rvalid, 1);
        check("b2b_second", a_rdata, 32'h0BAD_F00D);
        @(negedge clk);
        check("hold_v", a_rvalid, 0);
        check("hold_data", a_rdata, 32'h0BAD_F00D);

        // Reset with a load in flight.
        @(negedge clk);
        a_req = 1'b1; a_addr = 17'h100;
        @(posedge clk);
        #1 rst_n = 1'b0;
        a_req = 1'b0;
        #1 check("rst_flight_data", a_rdata, 0);
        check("rst_flight_valid", a_rvalid, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_late_pulse", a_rvalid, 0);
        end
        a_chk("lw_survive", 0, 2'd2, 0, 17'h100, 32'h0, 32'h1234_55EF, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
